// File: rtl/ex_pkg.sv
// Shared definitions for the execute stage: opcodes, FSM encoding, widths.
package ex_pkg;

  localparam int DATA_W_DEF = 6;
  localparam int ADR_W_DEF  = 6;

  localparam logic [1:0] ALU_ADD  = 2'b00;
  localparam logic [1:0] ALU_SUB  = 2'b01;
  localparam logic [1:0] ALU_MUL  = 2'b10;
  localparam logic [1:0] ALU_NAND = 2'b11;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MUL  = 2'd1;
  localparam logic [1:0] ST_HALT = 2'd2;

endpackage

// File: rtl/mul_seq.sv
// Sequential shift-add multiplier, one partial-product step per clock.
module mul_seq
  import ex_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int STEPS  = DATA_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [DATA_W-1:0]     a,
  input  logic [DATA_W-1:0]     b,
  output logic                  done,
  output logic [2*DATA_W-1:0]   product
);

  localparam int CNT_W = $clog2(STEPS + 1);

  logic                busy;
  logic [CNT_W-1:0]    cnt;
  logic [2*DATA_W-1:0] mcand;
  logic [2*DATA_W-1:0] acc;
  logic [2*DATA_W-1:0] acc_nx;
  logic [DATA_W-1:0]   mplier;

  assign acc_nx  = mplier[0] ? acc + mcand : acc;
  assign done    = busy && (cnt == CNT_W'(STEPS - 1));
  // product includes the step taken on the done edge
  assign product = acc_nx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy   <= 1'b0;
      cnt    <= '0;
      mcand  <= '0;
      acc    <= '0;
      mplier <= '0;
    end else if (start) begin
      busy   <= 1'b1;
      cnt    <= '0;
      mcand  <= {{DATA_W{1'b0}}, a};
      acc    <= '0;
      mplier <= b;
    end else if (busy) begin
      acc    <= acc_nx;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + 1'b1;
      if (done)
        busy <= 1'b0;
    end
  end

endmodule

// File: rtl/ex_stage.sv
// Execute stage: single-cycle ADD/SUB/NAND, multi-cycle MUL with
// upstream freeze, and a sticky HALT state.
module ex_stage
  import ex_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int ADR_W     = ADR_W_DEF,
  parameter int MUL_STEPS = DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid_in,
  input  logic              halted_in,
  input  logic [ADR_W-1:0]  write_adr_in,
  input  logic [1:0]        alu_inst_in,
  input  logic [DATA_W-1:0] data_in_1,
  input  logic [DATA_W-1:0] data_in_2,
  output logic              freeze,
  output logic              wb_en,
  output logic [ADR_W-1:0]  wb_adr,
  output logic [DATA_W-1:0] wb_data,
  output logic              flag_z,
  output logic              flag_c,
  output logic              halted_out
);

  logic [1:0]          state;
  logic [ADR_W-1:0]    mul_adr;
  logic [DATA_W:0]     alu_full;
  logic                mul_done;
  logic [2*DATA_W-1:0] product;
  logic                idle_v;
  logic                go_halt;
  logic                go_mul;
  logic                go_alu;
  logic                mul_fin;

  assign idle_v  = (state == ST_IDLE) && valid_in;
  assign go_halt = idle_v && halted_in;
  assign go_mul  = idle_v && !halted_in
                   && (alu_inst_in == ALU_MUL);
  assign go_alu  = idle_v && !halted_in
                   && (alu_inst_in != ALU_MUL);
  assign mul_fin = (state == ST_MUL) && mul_done;

  // top bit is carry for ADD, borrow for SUB, zero for NAND
  always_comb begin
    alu_full = '0;
    unique case (alu_inst_in)
      ALU_ADD:  alu_full = {1'b0, data_in_1} + {1'b0, data_in_2};
      ALU_SUB:  alu_full = {1'b0, data_in_1} - {1'b0, data_in_2};
      ALU_NAND: alu_full = {1'b0, ~(data_in_1 & data_in_2)};
      default:  alu_full = '0;
    endcase
  end

  mul_seq #(
    .DATA_W (DATA_W),
    .STEPS  (MUL_STEPS)
  ) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (go_mul),
    .a       (data_in_1),
    .b       (data_in_2),
    .done    (mul_done),
    .product (product)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      mul_adr    <= '0;
      freeze     <= 1'b0;
      wb_en      <= 1'b0;
      wb_adr     <= '0;
      wb_data    <= '0;
      flag_z     <= 1'b0;
      flag_c     <= 1'b0;
      halted_out <= 1'b0;
    end else begin
      wb_en <= 1'b0;
      unique case (1'b1)
        go_halt: begin
          state      <= ST_HALT;
          freeze     <= 1'b1;
          halted_out <= 1'b1;
        end
        go_mul: begin
          state   <= ST_MUL;
          freeze  <= 1'b1;
          mul_adr <= write_adr_in;
        end
        go_alu: begin
          wb_en   <= 1'b1;
          wb_adr  <= write_adr_in;
          wb_data <= alu_full[DATA_W-1:0];
          flag_c  <= alu_full[DATA_W];
          flag_z  <= (alu_full[DATA_W-1:0] == '0);
        end
        mul_fin: begin
          state   <= ST_IDLE;
          freeze  <= 1'b0;
          wb_en   <= 1'b1;
          wb_adr  <= mul_adr;
          wb_data <= product[DATA_W-1:0];
          flag_c  <= (product[2*DATA_W-1:DATA_W] != '0);
          flag_z  <= (product[DATA_W-1:0] == '0);
        end
        default: ;
      endcase
    end
  end

endmodule
